// File: rtl/mdu_pkg.sv
// Shared op codes, default latencies and op-class decode for the E-stage multiply/divide unit.
// Macro MDU_MADD_EN enables the accumulate ops (MADD/MADDU/MSUB/MSUBU).
package mdu_pkg;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  function automatic logic is_mult(input logic [3:0] op);
`ifdef MDU_MADD_EN
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) ||
           (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
`else
    return (op == OP_MULT) || (op == OP_MULTU);
`endif
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/e_mdu_ctrl_if.sv
// E-stage pipeline <-> multiply/divide unit bus; master is the pipeline, slave is the MDU.
interface e_mdu_ctrl_if;
  logic [3:0]  E_MDUOp;
  logic        E_Start;
  logic [31:0] E_RS;
  logic [31:0] E_RT;
  logic        E_Busy;
  logic        E_MDUStall;
  logic [31:0] E_MDUOut;

  modport master (
    output E_MDUOp, E_Start, E_RS, E_RT,
    input  E_Busy, E_MDUStall, E_MDUOut
  );

  modport slave (
    input  E_MDUOp, E_Start, E_RS, E_RT,
    output E_Busy, E_MDUStall, E_MDUOut
  );
endinterface

// File: rtl/mdu_arith.sv
// Combinational 64-bit {HI,LO} result for multiply, divide and (with MDU_MADD_EN) accumulate ops.
// Ops with no arithmetic result, and divide by zero, pass the committed {HI,LO} through unchanged.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] result
);

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        quot_s;
  logic [31:0]        rem_s;
  logic [31:0]        quot_u;
  logic [31:0]        rem_u;
  logic               div_ovf;

  assign prod_s  = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
  assign prod_u  = {32'd0, rs} * {32'd0, rt};
  assign div_ovf = (rs == 32'h8000_0000) && (rt == 32'hFFFF_FFFF);

  // Divider inputs are forced safe when the result would not be selected anyway
  always_comb begin
    quot_s = 32'd0;
    rem_s  = 32'd0;
    quot_u = 32'd0;
    rem_u  = 32'd0;
    if (rt != 32'd0) begin
      quot_u = rs / rt;
      rem_u  = rs % rt;
      if (div_ovf) begin
        quot_s = 32'h8000_0000;
        rem_s  = 32'd0;
      end else begin
        quot_s = $signed(rs) / $signed(rt);
        rem_s  = $signed(rs) % $signed(rt);
      end
    end
  end

  always_comb begin
    result = {hi, lo};
    case (op)
      OP_MULT:  result = prod_s;
      OP_MULTU: result = prod_u;
      OP_DIV:   if (rt != 32'd0) result = {rem_s, quot_s};
      OP_DIVU:  if (rt != 32'd0) result = {rem_u, quot_u};
`ifdef MDU_MADD_EN
      OP_MADD:  result = {hi, lo} + prod_s;
      OP_MADDU: result = {hi, lo} + prod_u;
      OP_MSUB:  result = {hi, lo} - prod_s;
      OP_MSUBU: result = {hi, lo} - prod_u;
`endif
      default:  result = {hi, lo};
    endcase
  end

endmodule

// File: rtl/e_mdu_ctrl.sv
// E-stage multiply/divide controller: IDLE/RUN FSM, latency down-counter, committed and pending HI/LO.
// Accumulate ops are built only with MDU_MADD_EN; otherwise their codes behave as NONE.
module e_mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic         clk,
  input  logic         reset,
  e_mdu_ctrl_if.slave  mdu
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  mdu_state_e         state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic [31:0]        hi_q;
  logic [31:0]        lo_q;
  logic [63:0]        pend_q;
  logic [63:0]        arith_res;
  logic               op_mult;
  logic               op_div;

  assign op_mult = is_mult(mdu.E_MDUOp);
  assign op_div  = is_div(mdu.E_MDUOp);

  mdu_arith u_arith (
    .op     (mdu.E_MDUOp),
    .rs     (mdu.E_RS),
    .rt     (mdu.E_RT),
    .hi     (hi_q),
    .lo     (lo_q),
    .result (arith_res)
  );

  // Commit happens on the edge where the counter reaches its terminal count of 1
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      pend_q  <= 64'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (mdu.E_Start) begin
            if (op_mult || op_div) begin
              pend_q  <= arith_res;
              cnt_q   <= op_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
              state_q <= ST_RUN;
              busy_q  <= 1'b1;
            end else if (mdu.E_MDUOp == OP_MTHI) begin
              hi_q <= mdu.E_RS;
            end else if (mdu.E_MDUOp == OP_MTLO) begin
              lo_q <= mdu.E_RS;
            end
          end
        end
        ST_RUN: begin
          if (cnt_q <= CNT_W'(1)) begin
            hi_q    <= pend_q[63:32];
            lo_q    <= pend_q[31:0];
            cnt_q   <= '0;
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mdu.E_Busy     = busy_q;
  assign mdu.E_MDUStall = busy_q | (mdu.E_Start & (op_mult | op_div));
  assign mdu.E_MDUOut   = (mdu.E_MDUOp == OP_MFHI) ? hi_q :
                          (mdu.E_MDUOp == OP_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_e_mdu_ctrl.sv
// Directed self-checking bench for e_mdu_ctrl with default latencies (mult 5, div 10).
module tb_e_mdu_ctrl;
  import mdu_pkg::*;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  int   n;
  logic [31:0] rd_hi;
  logic [31:0] rd_lo;

  e_mdu_ctrl_if bus ();

  e_mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .mdu   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
    bus.E_MDUOp = OP_MFHI;
    #1 h = bus.E_MDUOut;
    bus.E_MDUOp = OP_MFLO;
    #1 l = bus.E_MDUOut;
    bus.E_MDUOp = OP_NONE;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic exp_stall, input string tag);
    bus.E_MDUOp = op;
    bus.E_Start = 1'b1;
    bus.E_RS    = a;
    bus.E_RT    = b;
    #1 check({tag, "_stall"}, {31'd0, bus.E_MDUStall}, {31'd0, exp_stall});
    cyc();
    bus.E_Start = 1'b0;
    bus.E_MDUOp = OP_NONE;
  endtask

  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (bus.E_Busy === 1'b1 && cnt < 100) begin
      cyc();
      cnt++;
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b0;
    bus.E_MDUOp = OP_NONE;
    bus.E_Start = 1'b0;
    bus.E_RS = 32'd0;
    bus.E_RT = 32'd0;

    #2;
    check("reset_busy", {31'd0, bus.E_Busy}, 32'd0);
    read_hilo(rd_hi, rd_lo);
    check("reset_hi", rd_hi, 32'd0);
    check("reset_lo", rd_lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    cyc();

    // MULT signed
    issue(OP_MULT, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, "mult");
    check("mult_busy_rise", {31'd0, bus.E_Busy}, 32'd1);
    wait_idle(n);
    check("mult_busy_cycles", n, 32'd5);
    read_hilo(rd_hi, rd_lo);
    check("mult_hi", rd_hi, 32'hFFFF_FFFF);
    check("mult_lo", rd_lo, 32'hFFFF_FFFE);

    // MULTU same operands
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, "multu");
    wait_idle(n);
    check("multu_busy_cycles", n, 32'd5);
    read_hilo(rd_hi, rd_lo);
    check("multu_hi", rd_hi, 32'h0000_0001);
    check("multu_lo", rd_lo, 32'hFFFF_FFFE);

    // DIV -7/2, with MFLO during RUN returning the old LO
    issue(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 1'b1, "div");
    bus.E_MDUOp = OP_MFLO;
    #1 check("mflo_during_run", bus.E_MDUOut, 32'hFFFF_FFFE);
    bus.E_MDUOp = OP_NONE;
    wait_idle(n);
    check("div_busy_cycles", n, 32'd10);
    read_hilo(rd_hi, rd_lo);
    check("div_hi", rd_hi, 32'hFFFF_FFFF);
    check("div_lo", rd_lo, 32'hFFFF_FFFD);

    // DIVU by zero keeps HI/LO but still takes the full busy period
    issue(OP_DIVU, 32'h0000_0007, 32'h0000_0000, 1'b1, "divu0");
    wait_idle(n);
    check("divu0_busy_cycles", n, 32'd10);
    read_hilo(rd_hi, rd_lo);
    check("divu0_hi", rd_hi, 32'hFFFF_FFFF);
    check("divu0_lo", rd_lo, 32'hFFFF_FFFD);

    // Signed divide overflow corner
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "divovf");
    wait_idle(n);
    check("divovf_busy_cycles", n, 32'd10);
    read_hilo(rd_hi, rd_lo);
    check("divovf_hi", rd_hi, 32'h0000_0000);
    check("divovf_lo", rd_lo, 32'h8000_0000);

    // MTHI / MTLO
    issue(OP_MTHI, 32'h0000_1234, 32'd0, 1'b0, "mthi");
    check("mthi_busy", {31'd0, bus.E_Busy}, 32'd0);
    bus.E_MDUOp = OP_MFHI;
    #1 check("mfhi_after_mthi", bus.E_MDUOut, 32'h0000_1234);
    bus.E_MDUOp = OP_NONE;
    issue(OP_MTLO, 32'h0000_5678, 32'd0, 1'b0, "mtlo");
    read_hilo(rd_hi, rd_lo);
    check("mtlo_lo", rd_lo, 32'h0000_5678);
    check("mtlo_hi_kept", rd_hi, 32'h0000_1234);

    // Second start during RUN is ignored
    issue(OP_MULT, 32'd3, 32'd4, 1'b1, "mult34");
    cyc();
    bus.E_MDUOp = OP_MULT;
    bus.E_Start = 1'b1;
    bus.E_RS = 32'd5;
    bus.E_RT = 32'd5;
    #1 check("restart_stall", {31'd0, bus.E_MDUStall}, 32'd1);
    cyc();
    bus.E_Start = 1'b0;
    bus.E_MDUOp = OP_NONE;
    check("restart_stall_after", {31'd0, bus.E_MDUStall}, 32'd1);
    wait_idle(n);
    check("restart_remaining_cycles", n, 32'd3);
    cyc();
    check("restart_no_rerun", {31'd0, bus.E_Busy}, 32'd0);
    read_hilo(rd_hi, rd_lo);
    check("restart_hi", rd_hi, 32'd0);
    check("restart_lo", rd_lo, 32'd12);

    // Reset in RUN cycle 3 aborts without commit
    issue(OP_MULT, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, "mult_rst");
    cyc();
    cyc();
    reset = 1'b0;
    #1 check("rst_busy_immediate", {31'd0, bus.E_Busy}, 32'd0);
    read_hilo(rd_hi, rd_lo);
    check("rst_hi", rd_hi, 32'd0);
    check("rst_lo", rd_lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (8) cyc();
    check("rst_no_late_busy", {31'd0, bus.E_Busy}, 32'd0);
    read_hilo(rd_hi, rd_lo);
    check("rst_no_commit_hi", rd_hi, 32'd0);
    check("rst_no_commit_lo", rd_lo, 32'd0);

`ifdef MDU_MADD_EN
    issue(OP_MTHI, 32'h0000_0000, 32'd0, 1'b0, "madd_mthi");
    issue(OP_MTLO, 32'hFFFF_FFFF, 32'd0, 1'b0, "madd_mtlo");
    issue(OP_MADDU, 32'd1, 32'd1, 1'b1, "maddu");
    wait_idle(n);
    check("maddu_busy_cycles", n, 32'd5);
    read_hilo(rd_hi, rd_lo);
    check("maddu_hi", rd_hi, 32'h0000_0001);
    check("maddu_lo", rd_lo, 32'h0000_0000);
`else
    issue(OP_MTHI, 32'h0000_00AA, 32'd0, 1'b0, "madd_mthi");
    issue(OP_MTLO, 32'h0000_00BB, 32'd0, 1'b0, "madd_mtlo");
    issue(OP_MADDU, 32'd1, 32'd1, 1'b0, "maddu_off");
    check("maddu_off_busy", {31'd0, bus.E_Busy}, 32'd0);
    cyc();
    check("maddu_off_busy_later", {31'd0, bus.E_Busy}, 32'd0);
    read_hilo(rd_hi, rd_lo);
    check("maddu_off_hi", rd_hi, 32'h0000_00AA);
    check("maddu_off_lo", rd_lo, 32'h0000_00BB);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/e_mdu_ctrl.md
E_MDU_CTRL -- requirements
Module: e_mdu_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, meaning Busy cycles for mult/multu/madd/maddu/msub/msubu.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, meaning Busy cycles for div/divu.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port E_MDUOp  input  4  op code: NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO, MADD, MADDU, MSUB, MSUBU.
REQ-006 SHALL have port E_Start  input  1  qualifies a multiply, divide, MTHI or MTLO op in E this cycle.
REQ-007 SHALL have port E_RS  input  32  operand A.
REQ-008 SHALL have port E_RT  input  32  operand B.
REQ-009 SHALL have port E_Busy  output  1  a multiply or divide is in flight.
REQ-010 SHALL have port E_MDUStall  output  1  E_Busy | (E_Start & op is multiply/divide), combinational, consumed by the hazard unit.
REQ-011 SHALL have port E_MDUOut  output  32  HI for MFHI, LO for MFLO, else 0, combinational from committed registers.

Function
REQ-012 SHALL have states IDLE and RUN plus a down-counter, a committed HI/LO pair and a pending HI/LO pair.
REQ-013 SHALL, in IDLE with E_Start and a multiply/divide op at edge t, capture the 64-bit result into pending, load the counter with the op latency N, enter RUN and drive E_Busy=1 from t+1.
REQ-014 SHALL decrement the counter every RUN cycle, copy pending to committed HI/LO at edge t+N, and return to IDLE with E_Busy=0 after that same edge (E_Busy high exactly N cycles).
REQ-015 SHALL compute MULT/MULTU as signed/unsigned 32x32->64, {HI,LO}=product.
REQ-016 SHALL compute DIV/DIVU with LO=quotient and HI=remainder, truncating toward zero, remainder sign equal to dividend sign.
REQ-017 SHALL leave HI/LO unchanged on divide by zero, while still running the full DIV_CYCLES busy period.
REQ-018 SHALL compute DIV of 0x80000000 by 0xFFFFFFFF as LO=0x80000000, HI=0.
REQ-019 SHALL write MTHI/MTLO to committed HI/LO at the sampling edge when IDLE; E_Busy stays 0.
REQ-020 SHALL ignore any E_Start while in RUN (no restart, no MTHI/MTLO write); upstream stalling prevents this case.
REQ-021 SHALL make MFHI/MFLO read the committed value only, never pending, including during RUN.

Reset
REQ-022 SHALL, on reset low, immediately force IDLE, counter=0, E_Busy=0, committed and pending HI/LO=0, independent of clk.
REQ-023 SHALL abort an in-flight operation on reset mid-RUN with no commit; the first edge after release samples normally.

Configuration
REQ-024 SHALL support macro MDU_MADD_EN: when defined, MADD/MADDU/MSUB/MSUBU add or subtract the 64-bit signed/unsigned product to or from the committed {HI,LO} with MULT_CYCLES latency.
REQ-025 SHALL, when MDU_MADD_EN is undefined, treat those four codes as NONE: no start, no stall.

Structure
REQ-026 SHALL take op-code localparams and default latencies from shared package mdu_pkg.
REQ-027 SHALL place 64-bit result arithmetic in combinational sub-module mdu_arith; e_mdu_ctrl holds only FSM, counter and registers.

Verification
REQ-028 SHALL verify: MULT 0xFFFFFFFF x 0x00000002 -> E_Busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE; MULTU on the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-029 SHALL verify: DIV -7 / 2 -> E_Busy high 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7 / 0 -> busy 10 cycles, HI/LO unchanged.
REQ-030 SHALL verify: MTHI 0x1234 then MFHI next cycle -> E_MDUOut=0x1234; MFLO during RUN -> returns the previous LO.
REQ-031 SHALL verify: second MULT Start on cycle 2 of RUN -> ignored; result equals first op; E_MDUStall=1 throughout.
REQ-032 SHALL verify: reset low at RUN cycle 3 -> E_Busy=0 immediately, HI=LO=0, no later commit.
REQ-033 SHALL verify: with MDU_MADD_EN and HI=0, LO=0xFFFFFFFF, MADDU 1x1 -> HI=1, LO=0; without MDU_MADD_EN -> no busy, HI/LO unchanged.
